// File: rtl/tick_sequencer.sv
// Programmable tick / square-wave generator with burst or continuous runs and
// boundary-aligned reconfiguration over a valid/ready config port.
module tick_sequencer #(
  parameter int unsigned DIV_W           = 16,
  parameter int unsigned COUNT_W         = 16,
  parameter int unsigned DEFAULT_DIVISOR = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [DIV_W-1:0]   cfg_divisor_i,
  input  logic [COUNT_W-1:0] cfg_count_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               tick_o,
  output logic               divided_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [DIV_W-1:0]   DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_RST = DIV_W'(DEFAULT_DIVISOR);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIV_W-1:0]   div;
    logic [COUNT_W-1:0] cnt;
  } cfg_t;

  state_e             state_q, state_d;
  cfg_t               act_q, act_d;
  cfg_t               pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [DIV_W-1:0]   phase_q, phase_d;
  logic [COUNT_W-1:0] left_q, left_d;
  logic               stop_req_q, stop_req_d;
  logic               tick_q, tick_d;
  logic               divided_q, divided_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_ready_q, cfg_ready_d;

  cfg_t               cfg_in;
  logic               cfg_acc;
  logic               end_run;

  assign cfg_acc = cfg_valid_i && cfg_ready_q;

  // Normalise the offered config; a zero divisor behaves as one.
  always_comb begin
    cfg_in.div = (cfg_divisor_i == '0) ? DIV_ONE : cfg_divisor_i;
    cfg_in.cnt = cfg_count_i;
  end

  // Next-state logic: sequencing, config staging and registered output values.
  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    phase_d      = phase_q;
    left_d       = left_q;
    stop_req_d   = stop_req_q;
    end_run      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        stop_req_d = 1'b0;
        // A config staged during the final period is applied once stopped.
        if (pend_valid_q) begin
          act_d        = pend_q;
          pend_valid_d = 1'b0;
        end else if (cfg_acc) begin
          act_d = cfg_in;
        end
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d = S_RUN;
          phase_d = act_d.div - DIV_ONE;
          left_d  = act_d.cnt;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          stop_req_d = 1'b1;
        end
        if (phase_q == '0) begin
          end_run = stop_req_q || stop_i ||
                    ((act_q.cnt != '0) && (left_q == CNT_ONE));
          if (pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
            left_d       = pend_q.cnt;
          end else if (act_q.cnt != '0) begin
            left_d = left_q - CNT_ONE;
          end
          phase_d = act_d.div - DIV_ONE;
          if (end_run) begin
            state_d    = S_DONE;
            stop_req_d = 1'b0;
          end
        end else begin
          phase_d = phase_q - DIV_ONE;
        end
        if (cfg_acc) begin
          pend_d       = cfg_in;
          pend_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tick_d      = (state_d == S_RUN) && (phase_d == '0);
    divided_d   = (state_d == S_RUN) && (act_d.div != DIV_ONE) &&
                  (phase_d >= (act_d.div >> 1));
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = !pend_valid_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      act_q        <= '{div: DIV_RST, cnt: '0};
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      phase_q      <= '0;
      left_q       <= '0;
      stop_req_q   <= 1'b0;
      tick_q       <= 1'b0;
      divided_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      phase_q      <= phase_d;
      left_q       <= left_d;
      stop_req_q   <= stop_req_d;
      tick_q       <= tick_d;
      divided_q    <= divided_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign tick_o      = tick_q;
  assign divided_o   = divided_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed scenarios plus random traffic, checked
// every cycle against an absolute-cycle-number reference model.
module tb_tick_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [DW-1:0] cfg_divisor_i;
  logic [CW-1:0] cfg_count_i;
  logic          start_i;
  logic          stop_i;
  logic          tick_o;
  logic          divided_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  tick_sequencer #(.DIV_W(DW), .COUNT_W(CW), .DEFAULT_DIVISOR(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_divisor_i(cfg_divisor_i), .cfg_count_i(cfg_count_i),
    .start_i(start_i), .stop_i(stop_i),
    .tick_o(tick_o), .divided_o(divided_o), .busy_o(busy_o), .done_o(done_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_log[$];
  int done_log[$];
  int div_hi;

  // Reference model: mode 0=idle 1=run 2=done; next tick kept as absolute cycle.
  int m_mode, m_div, m_cnt, m_pdiv, m_pcnt, m_next, m_left;
  bit m_pv, m_stop;

  task automatic model_reset();
    m_mode = 0; m_div = 1; m_cnt = 0; m_pv = 0; m_pdiv = 0; m_pcnt = 0;
    m_next = 0; m_left = 0; m_stop = 0;
  endtask

  task automatic model_step(input bit v, input int d, input int c,
                            input bit st, input bit sp, input bit rs);
    int nd;
    bit acc;
    bit ends;
    nd  = (d == 0) ? 1 : d;
    acc = v && !m_pv;
    if (rs) begin
      model_reset();
      return;
    end
    if (m_mode != 1) begin
      if (m_pv) begin
        m_div = m_pdiv; m_cnt = m_pcnt; m_pv = 0;
      end else if (acc) begin
        m_div = nd; m_cnt = c;
      end
      m_stop = 0;
      if (m_mode == 2) m_mode = 0;
      else if (st) begin
        m_mode = 1; m_next = cyc + m_div; m_left = m_cnt;
      end
    end else begin
      if (cyc == m_next) begin
        ends = m_stop || sp || (m_cnt != 0 && m_left == 1);
        if (m_pv) begin
          m_div = m_pdiv; m_cnt = m_pcnt; m_pv = 0; m_left = m_cnt;
        end else if (m_cnt != 0) begin
          m_left = m_left - 1;
        end
        if (ends) begin
          m_mode = 2; m_stop = 0;
        end else begin
          m_next = cyc + m_div;
        end
      end else if (sp) begin
        m_stop = 1;
      end
      if (acc) begin
        m_pv = 1; m_pdiv = nd; m_pcnt = c;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare registered outputs, advance model.
  task automatic step(input bit v, input int d, input int c,
                      input bit st, input bit sp, input bit rs);
    @(negedge clk_i);
    cfg_valid_i   = v;
    cfg_divisor_i = DW'(d);
    cfg_count_i   = CW'(c);
    start_i       = st;
    stop_i        = sp;
    reset_i       = rs;
    chk("busy",      busy_o,      m_mode == 1);
    chk("done",      done_o,      m_mode == 2);
    chk("cfg_ready", cfg_ready_o, !m_pv);
    chk("tick",      tick_o,      (m_mode == 1) && (cyc == m_next));
    chk("divided",   divided_o,   (m_mode == 1) && (m_div > 1) &&
                                  ((m_next - cyc) >= (m_div / 2)));
    if (tick_o)    tick_log.push_back(cyc);
    if (done_o)    done_log.push_back(cyc);
    if (divided_o) div_hi++;
    model_step(v, d, c, st, sp, rs);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_logs();
    tick_log.delete();
    done_log.delete();
    div_hi = 0;
  endtask

  int t;

  initial begin
    cfg_valid_i = 0; cfg_divisor_i = '0; cfg_count_i = '0;
    start_i = 0; stop_i = 0; reset_i = 1;
    model_reset();
    clear_logs();
    repeat (2) @(posedge clk_i);
    step(0, 0, 0, 0, 0, 1);
    idle(2);

    // 1: div=4 cnt=3 burst
    step(1, 4, 3, 0, 0, 0);
    clear_logs();
    t = cyc;
    step(0, 0, 0, 1, 0, 0);
    idle(16);
    chk_int("t1_ntick", tick_log.size(), 3);
    chk_int("t1_tick0", tick_log[0] - t, 4);
    chk_int("t1_tick2", tick_log[2] - t, 12);
    chk_int("t1_done",  done_log[0] - t, 13);

    // 2: div=1 continuous, stop on the 5th tick
    step(1, 1, 0, 0, 0, 0);
    clear_logs();
    t = cyc;
    step(0, 0, 0, 1, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 1, 0);
    idle(4);
    chk_int("t2_ntick", tick_log.size(), 5);
    chk_int("t2_tick0", tick_log[0] - t, 1);
    chk_int("t2_done",  done_log[0] - t, 6);

    // 3: div=5 continuous, reconfigure to div=2 mid-period
    step(1, 5, 0, 0, 0, 0);
    clear_logs();
    t = cyc;
    step(0, 0, 0, 1, 0, 0);
    idle(1);
    step(1, 2, 0, 0, 0, 0);
    idle(7);
    step(0, 0, 0, 0, 1, 0);
    idle(4);
    chk_int("t3_tick0", tick_log[0] - t, 5);
    chk_int("t3_tick1", tick_log[1] - t, 7);
    chk_int("t3_tick2", tick_log[2] - t, 9);

    // 4: div=6 cnt=2, stop with the last tick
    step(1, 6, 2, 0, 0, 0);
    clear_logs();
    t = cyc;
    step(0, 0, 0, 1, 0, 0);
    idle(11);
    step(0, 0, 0, 0, 1, 0);
    idle(4);
    chk_int("t4_ndone", done_log.size(), 1);
    chk_int("t4_done",  done_log[0] - t, 13);
    chk_int("t4_divhi", div_hi, 6);

    // 5: config and start in the same cycle; zero divisor acts as one
    clear_logs();
    t = cyc;
    step(1, 3, 1, 1, 0, 0);
    idle(6);
    chk_int("t5_tick0", tick_log[0] - t, 3);
    clear_logs();
    t = cyc;
    step(1, 0, 2, 1, 0, 0);
    idle(5);
    chk_int("t5_ntick", tick_log.size(), 2);
    chk_int("t5_tick0z", tick_log[0] - t, 1);
    chk_int("t5_done",  done_log[0] - t, 3);

    // 6: reset mid-run with a pending config
    step(1, 8, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    step(1, 3, 0, 0, 0, 0);
    clear_logs();
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    chk_int("t6_ndone", done_log.size(), 0);
    t = cyc;
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    chk_int("t6_tick0", tick_log[0] - t, 1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(7) == 0, int'($urandom_range(7)), int'($urandom_range(4)),
           $urandom_range(9) == 0, $urandom_range(19) == 0,
           $urandom_range(199) == 0);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
